// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the mips_cpu_bus memory responder
//   RESET_VECTOR : default byte address mapped to word 0
//   WAIT_W       : width of the wait-state counter
//   byte_lanes_t : 32-bit word viewed as four little-endian byte lanes
//   bus_req_t    : request fields captured by the stability checker
package mips_bus_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam int          WAIT_W       = 4;

    typedef logic [3:0][7:0] byte_lanes_t;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
    } bus_req_t;

    function automatic byte_lanes_t lane_mask(input byte_lanes_t d, input logic [3:0] be);
        byte_lanes_t m;
        for (int i = 0; i < 4; i++) m[i] = be[i] ? d[i] : 8'h00;
        return m;
    endfunction

endpackage

// File: rtl/bus_ram_bytelane_array.sv
// bus_ram_bytelane_array: DEPTH_WORDS x 4 byte-lane RAM, lane-masked write port, registered read port
//   clk, reset : clock and synchronous active-high reset (clears read register only)
//   i_we, i_waddr, i_wmask, i_wdata : write strobe, word index, lane mask, data
//   i_re, i_rhit, i_raddr, i_rmask  : read strobe, address-valid, word index, lane mask
//   o_rdata    : registered read data, held until the next read strobe
module bus_ram_bytelane_array
    import mips_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [3:0]    i_wmask,
    input  byte_lanes_t   i_wdata,
    input  logic          i_re,
    input  logic          i_rhit,
    input  logic [AW-1:0] i_raddr,
    input  logic [3:0]    i_rmask,
    output byte_lanes_t   o_rdata
);

    byte_lanes_t r_mem [DEPTH_WORDS];
    byte_lanes_t r_rdata;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (i_we && i_wmask[i]) r_mem[i_waddr][i] <= i_wdata[i];
    end

    // a miss (out of range or halt fetch) returns zero without touching the array
    always_ff @(posedge clk) begin
        if (reset)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= i_rhit ? lane_mask(r_mem[i_raddr], i_rmask) : '0;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_bus_mem_responder.sv
// mips_bus_mem_responder: memory target for the mips_cpu_bus initiator with programmable wait states
//   clk, reset      : clock and synchronous active-high reset
//   address         : byte address, bits [1:0] ignored
//   read, write     : request strobes
//   writedata       : write data, lane i = writedata[8i+7:8i]
//   byteenable      : lane enables
//   waitrequest     : 1 = request not accepted this cycle
//   readdata        : registered read data
//   protocol_error  : sticky, set on unstable request or read&write together
module mips_bus_mem_responder
    import mips_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        protocol_error
);

    localparam int                AW       = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_CYCLES);

    logic [WAIT_W-1:0] r_cnt;
    logic              r_pending;
    bus_req_t          r_hold;
    logic              r_err;

    logic        w_req;
    logic        w_accept;
    logic [31:0] w_index;
    logic        w_hit;
    bus_req_t    w_fields;
    logic        w_changed;
    byte_lanes_t w_rdata;

    assign w_req       = read | write;
    assign waitrequest = reset | (w_req & (r_cnt != WAIT_LIM));
    assign w_accept    = w_req & ~waitrequest;
    assign w_index     = (address - BASE_ADDR) >> 2;
    assign w_hit       = w_index < 32'(DEPTH_WORDS);
    assign w_fields    = '{read, write, address, writedata, byteenable};
    // any field moving (including the request dropping) after the first wait cycle is a violation
    assign w_changed   = r_pending & (w_fields != r_hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cnt     <= (w_accept | ~w_req) ? '0 : (r_cnt < WAIT_LIM ? r_cnt + 1'b1 : r_cnt);
            r_pending <= w_req & waitrequest;
            r_err     <= r_err | w_changed | (w_accept & read & write);
        end
    end

    always_ff @(posedge clk) begin
        if (w_req && waitrequest && !r_pending) r_hold <= w_fields;
    end

    bus_ram_bytelane_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_accept & write & w_hit),
        .i_waddr (w_index[AW-1:0]),
        .i_wmask (byteenable),
        .i_wdata (writedata),
        .i_re    (w_accept & read & ~write),
        .i_rhit  (w_hit & (address != 32'h0)),
        .i_raddr (w_index[AW-1:0]),
        .i_rmask (byteenable),
        .o_rdata (w_rdata)
    );

    assign readdata       = w_rdata;
    assign protocol_error = r_err;

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// tb_mips_bus_mem_responder: randomized self-checking bench against a word-array reference model
module tb_mips_bus_mem_responder;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_read = 1'b0, a_write = 1'b0, b_read = 1'b0, b_write = 1'b0;
    logic [31:0] a_addr = '0, a_wd = '0, b_addr = '0, b_wd = '0;
    logic [3:0]  a_be = '0, b_be = '0;
    logic        a_wait, b_wait, a_err, b_err;
    logic [31:0] a_rd, b_rd;

    int          vec = 0, errs = 0;
    bit [31:0]   ma [1024];
    bit [31:0]   mb [1024];
    bit [31:0]   a_rdx = 0, b_rdx = 0;
    bit          a_errx = 0, b_errx = 0;

    always #5 clk = ~clk;

    mips_bus_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(2), .INIT_FILE("")
    ) u_a (
        .clk(clk), .reset(reset), .address(a_addr), .read(a_read), .write(a_write),
        .writedata(a_wd), .byteenable(a_be), .waitrequest(a_wait), .readdata(a_rd),
        .protocol_error(a_err)
    );

    mips_bus_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(0), .INIT_FILE("")
    ) u_b (
        .clk(clk), .reset(reset), .address(b_addr), .read(b_read), .write(b_write),
        .writedata(b_wd), .byteenable(b_be), .waitrequest(b_wait), .readdata(b_rd),
        .protocol_error(b_err)
    );

    function automatic bit [31:0] lanes(input bit [31:0] d, input bit [3:0] be);
        bit [31:0] r = 0;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // one complete bus transfer on instance a (sel=0) or b (sel=1), checked against the model
    task automatic xfer(input bit sel, input bit rd, input bit wr, input bit [31:0] addr,
                        input bit [31:0] wd, input bit [3:0] be, input int exp_waits);
        int        n = 0;
        bit        acc = 0;
        bit [31:0] idx = (addr - BASE) / 4;
        bit [31:0] old, nw, got;
        @(negedge clk);
        if (sel) begin b_read = rd; b_write = wr; b_addr = addr; b_wd = wd; b_be = be; end
        else     begin a_read = rd; a_write = wr; a_addr = addr; a_wd = wd; a_be = be; end
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!(sel ? b_wait : a_wait)) begin acc = 1; break; end
            n++;
            @(negedge clk);
        end
        vec++;
        if (!acc) begin
            errs++;
            $display("FAIL accept_timeout dut=%0d addr=%h waited %0d cycles", sel, addr, n);
        end else if (n !== exp_waits) begin
            errs++;
            $display("FAIL wait_count dut=%0d addr=%h got %0d exp %0d", sel, addr, n, exp_waits);
        end
        if (acc) begin
            if (wr && idx < 1024) begin
                old = sel ? mb[idx] : ma[idx];
                nw  = (old & ~lanes(32'hFFFFFFFF, be)) | lanes(wd, be);
                if (sel) mb[idx] = nw; else ma[idx] = nw;
            end
            if (rd && wr) begin
                if (sel) b_errx = 1; else a_errx = 1;
            end else if (rd) begin
                old = (addr != 0 && idx < 1024) ? (sel ? mb[idx] : ma[idx]) : 32'h0;
                if (sel) b_rdx = lanes(old, be); else a_rdx = lanes(old, be);
            end
        end
        @(posedge clk);
        #1;
        if (sel) begin b_read = 0; b_write = 0; end else begin a_read = 0; a_write = 0; end
        @(negedge clk);
        got = sel ? b_rd : a_rd;
        vec++;
        if (got !== (sel ? b_rdx : a_rdx)) begin
            errs++;
            $display("FAIL readdata dut=%0d addr=%h be=%h got %h exp %h", sel, addr, be, got, sel ? b_rdx : a_rdx);
        end
        vec++;
        if ((sel ? b_err : a_err) !== (sel ? b_errx : a_errx)) begin
            errs++;
            $display("FAIL protocol_error dut=%0d got %b exp %b", sel, sel ? b_err : a_err, sel ? b_errx : a_errx);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++;
        if ({a_wait, b_wait, a_err, b_err} !== 4'b1100 || a_rd !== 0 || b_rd !== 0) begin
            errs++;
            $display("FAIL reset_state got wait=%b%b err=%b%b rd=%h/%h exp 11 00 0/0", a_wait, b_wait, a_err, b_err, a_rd, b_rd);
        end
        reset = 0;
        #1;
        vec++;
        if ({a_wait, b_wait} !== 2'b00) begin
            errs++;
            $display("FAIL idle_wait got %b%b exp 00", a_wait, b_wait);
        end
    endtask

    task automatic test_spec_sequence;
        xfer(0, 0, 1, BASE + 4, 32'hDEADBEEF, 4'hF, 2);
        xfer(0, 1, 0, BASE + 4, 0, 4'b0101, 2);
        vec++;
        if (a_rd !== 32'h00AD00EF) begin
            errs++;
            $display("FAIL partial_read got %h exp 00ad00ef", a_rd);
        end
        repeat (3) @(negedge clk);
        vec++;
        if (a_rd !== 32'h00AD00EF) begin
            errs++;
            $display("FAIL read_hold got %h exp 00ad00ef", a_rd);
        end
        xfer(0, 0, 1, BASE + 4, 32'h0, 4'hF, 2);
        xfer(0, 0, 1, BASE + 4, 32'h0000F100, 4'b0010, 2);
        xfer(0, 1, 0, BASE + 4, 0, 4'hF, 2);
        vec++;
        if (a_rd !== 32'h0000F100) begin
            errs++;
            $display("FAIL lane_write got %h exp 0000f100", a_rd);
        end
    endtask

    task automatic test_zero_wait;
        xfer(1, 0, 1, BASE, 32'hCAFEF00D, 4'hF, 0);
        xfer(1, 1, 0, BASE, 0, 4'hF, 0);
        xfer(1, 1, 0, 32'h0, 0, 4'hF, 0);
        xfer(1, 1, 0, BASE, 0, 4'hF, 0);
        xfer(1, 1, 0, BASE + 32'h1000, 0, 4'hF, 0);
        vec++;
        if (b_rd !== 32'h0) begin
            errs++;
            $display("FAIL out_of_range_read got %h exp 0", b_rd);
        end
    endtask

    task automatic test_random;
        bit [31:0] addr;
        for (int w = 0; w < 16; w++) xfer(0, 0, 1, BASE + 4 * w, $urandom, 4'hF, 2);
        for (int t = 0; t < 80; t++) begin
            int kind = $urandom_range(0, 9);
            addr = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            if (kind == 8) addr = BASE + 4 * (1024 + $urandom_range(0, 15));
            if (kind == 9) addr = BASE - 4 * $urandom_range(1, 16);
            xfer(0, kind >= 4 && kind < 8 || kind == 9, kind < 4 || kind == 8, addr, $urandom, 4'($urandom), 2);
        end
        for (int w = 0; w < 16; w++) xfer(0, 1, 0, BASE + 4 * w, 0, 4'hF, 2);
        for (int w = 0; w < 8; w++) xfer(1, 1, 0, 32'h0, 0, 4'($urandom), 0);
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 6; t++) begin
            bit [31:0] addr = BASE + 4 * $urandom_range(0, 15);
            xfer(0, 0, 1, addr, $urandom, 4'($urandom), 2);
            xfer(0, 1, 0, addr, 0, 4'hF, 2);
            xfer(1, 0, 1, BASE + 4 * t, $urandom, 4'hF, 0);
            xfer(1, 1, 0, BASE + 4 * t, 0, 4'($urandom), 0);
        end
    endtask

    task automatic test_protocol_change;
        @(negedge clk);
        a_write = 1; a_addr = BASE + 12; a_wd = 32'h11111111; a_be = 4'hF;
        @(negedge clk);
        a_addr = BASE + 16; a_wd = 32'h22222222;
        #1;
        vec++;
        if (a_wait !== 1'b1) begin
            errs++;
            $display("FAIL change_wait got %b exp 1", a_wait);
        end
        @(negedge clk);
        #1;
        vec++;
        if (a_wait !== 1'b0) begin
            errs++;
            $display("FAIL change_accept got %b exp 0", a_wait);
        end
        @(posedge clk);
        #1;
        a_write = 0;
        ma[4] = 32'h22222222;
        a_errx = 1;
        @(negedge clk);
        vec++;
        if (a_err !== 1'b1) begin
            errs++;
            $display("FAIL change_error got %b exp 1", a_err);
        end
        xfer(0, 1, 0, BASE + 12, 0, 4'hF, 2);
        xfer(0, 1, 0, BASE + 16, 0, 4'hF, 2);
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        vec++;
        if (a_err !== 1'b0 || a_rd !== 32'h0) begin
            errs++;
            $display("FAIL reset_clear got err=%b rd=%h exp 0/0", a_err, a_rd);
        end
        reset = 0;
        a_errx = 0; b_errx = 0; a_rdx = 0; b_rdx = 0;
        xfer(0, 1, 0, BASE + 16, 0, 4'hF, 2);
    endtask

    task automatic test_rw_both;
        xfer(0, 1, 1, BASE + 8, 32'h12345678, 4'hF, 2);
        xfer(0, 1, 0, BASE + 8, 0, 4'hF, 2);
        vec++;
        if (a_rd !== 32'h12345678) begin
            errs++;
            $display("FAIL rw_both_data got %h exp 12345678", a_rd);
        end
    endtask

    task automatic test_reset_midwait;
        xfer(0, 1, 0, BASE + 24, 0, 4'hF, 2);
        @(negedge clk);
        a_write = 1; a_addr = BASE + 24; a_wd = ~ma[6]; a_be = 4'hF;
        @(negedge clk);
        reset = 1;
        #1;
        vec++;
        if (a_wait !== 1'b1) begin
            errs++;
            $display("FAIL reset_wait got %b exp 1", a_wait);
        end
        @(negedge clk);
        vec++;
        if (a_rd !== 32'h0 || a_err !== 1'b0) begin
            errs++;
            $display("FAIL midwait_reset got rd=%h err=%b exp 0/0", a_rd, a_err);
        end
        a_write = 0;
        reset = 0;
        a_errx = 0; b_errx = 0; a_rdx = 0; b_rdx = 0;
        #1;
        vec++;
        if (a_wait !== 1'b0) begin
            errs++;
            $display("FAIL post_reset_wait got %b exp 0", a_wait);
        end
        xfer(0, 1, 0, BASE + 24, 0, 4'hF, 2);
    endtask

    initial begin
        test_reset;
        test_spec_sequence;
        test_zero_wait;
        test_random;
        test_back_to_back;
        test_protocol_change;
        pulse_reset;
        test_rw_both;
        test_reset_midwait;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
